// File: rtl/ram_wr_sequencer_pkg.sv
// Shared widths and state encoding for the 8x3 RAM write-side sequencer.
// Read-side logic imports the same widths so both ends agree on the RAM shape.
package ram_wr_sequencer_pkg;

   localparam int RWS_DATA_W = 3;
   localparam int RWS_ADDR_W = 3;
   localparam int RWS_DEPTH  = 8;

   typedef logic [2:0] rws_state_t;

   localparam rws_state_t ST_IDLE   = 3'd0;
   localparam rws_state_t ST_FILL   = 3'd1;
   localparam rws_state_t ST_CLEAR  = 3'd2;
   localparam rws_state_t ST_DONE_F = 3'd3;
   localparam rws_state_t ST_DONE_C = 3'd4;

endpackage

// File: rtl/ram_wr_sequencer.sv
// Write-side front end for the 8x3 dual-port RAM.
// Loads one frame of DEPTH words from a valid/ready stream into addresses
// 0..DEPTH-1, or zero-fills the whole RAM one address per cycle.
//
// Ports:
//   clk, rst_n        write clock (RAM clk_wr) and synchronous active-low reset
//   start, clear_req  frame fill / zero sweep requests
//   in_valid, in_data upstream stream; in_ready is the handshake reply
//   wr_en, ram_add,   registered RAM write port
//   data_in
//   busy              FILL or CLEAR in progress
//   frame_done,       one-cycle pulses, aligned with the final RAM write
//   clear_done
//   fill_count        words accepted in the current/last frame, 0..DEPTH
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for clear_req (priority) or start
// FILL    | accepting stream words, one RAM write per transfer
// CLEAR   | writing zero to ptr each cycle, ascending
// DONE_F  | last frame word on the RAM port, frame_done pulse
// DONE_C  | last zero on the RAM port, clear_done pulse
module ram_wr_sequencer
   import ram_wr_sequencer_pkg::*;
#(
   parameter int DATA_W = RWS_DATA_W,
   parameter int ADDR_W = RWS_ADDR_W,
   parameter int DEPTH  = RWS_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clear_req,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] ram_add,
   output logic [DATA_W-1:0] data_in,
   output logic              busy,
   output logic              frame_done,
   output logic              clear_done,
   output logic [ADDR_W:0]   fill_count
);

   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH-1);
   localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

   rws_state_t        state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]   fill_count_q, fill_count_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] ram_add_q, ram_add_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              xfer;

   // rst_n gates in_ready so nothing is handshaken while reset is held,
   // even before the first reset edge has settled the state register.
   assign in_ready = (state_q == ST_FILL) & ~clear_req & rst_n;
   assign xfer     = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      fill_count_d = fill_count_q;
      wr_en_d      = 1'b0;
      ram_add_d    = ram_add_q;
      data_in_d    = data_in_q;
      case (state_q)
         ST_IDLE: begin
            if (clear_req) begin
               state_d      = ST_CLEAR;
               ptr_d        = '0;
               fill_count_d = '0;
            end else if (start) begin
               state_d      = ST_FILL;
               ptr_d        = '0;
               fill_count_d = '0;
            end
         end
         ST_FILL: begin
            if (clear_req) begin
               // abandon the partial frame; in_ready is already low this cycle
               state_d      = ST_CLEAR;
               ptr_d        = '0;
               fill_count_d = '0;
            end else if (xfer) begin
               wr_en_d   = 1'b1;
               ram_add_d = ptr_q[ADDR_W-1:0];
               data_in_d = in_data;
               ptr_d     = ptr_q + 1'b1;
               if (fill_count_q != FULL_CNT) fill_count_d = fill_count_q + 1'b1;
               if (ptr_q == LAST_PTR) state_d = ST_DONE_F;
            end
         end
         ST_CLEAR: begin
            wr_en_d   = 1'b1;
            ram_add_d = ptr_q[ADDR_W-1:0];
            data_in_d = '0;
            ptr_d     = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) state_d = ST_DONE_C;
         end
         ST_DONE_F,
         ST_DONE_C: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         fill_count_q <= '0;
         wr_en_q      <= 1'b0;
         ram_add_q    <= '0;
         data_in_q    <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         fill_count_q <= fill_count_d;
         wr_en_q      <= wr_en_d;
         ram_add_q    <= ram_add_d;
         data_in_q    <= data_in_d;
      end
   end

   assign wr_en      = wr_en_q;
   assign ram_add    = ram_add_q;
   assign data_in    = data_in_q;
   assign fill_count = fill_count_q;
   assign busy       = (state_q == ST_FILL) | (state_q == ST_CLEAR);
   assign frame_done = (state_q == ST_DONE_F);
   assign clear_done = (state_q == ST_DONE_C);

endmodule

// File: tb/tb_ram_wr_sequencer.sv
// Bench for ram_wr_sequencer: a table of per-cycle vectors for reset and a
// back-to-back frame, then hand-written throttle / clear / abort / reset
// sequences. A behavioural 8x3 RAM on the write port holds the written data.
module tb_ram_wr_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       clear_req;
   logic       in_valid;
   logic [2:0] in_data;
   logic       in_ready;
   logic       wr_en;
   logic [2:0] ram_add;
   logic [2:0] data_in;
   logic       busy;
   logic       frame_done;
   logic       clear_done;
   logic [3:0] fill_count;

   logic [2:0] mem [8];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic       rst_n, start, clr, vld;
      logic [2:0] din;
      int         rdy;
      int         wr, add, dat, bsy, fd, cd, cnt;
   } vec_t;

   vec_t vecs[$];

   ram_wr_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .clear_req  (clear_req),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .ram_add    (ram_add),
      .data_in    (data_in),
      .busy       (busy),
      .frame_done (frame_done),
      .clear_done (clear_done),
      .fill_count (fill_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) if (wr_en) mem[ram_add] <= data_in;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   task automatic drive(input logic r, input logic s, input logic c, input logic v,
                        input logic [2:0] d);
      rst_n = r; start = s; clear_req = c; in_valid = v; in_data = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int wr, input int add, input int dat,
                          input int bsy, input int fd, input int cd, input int cnt);
      chk({tag, ".wr_en"},      int'(wr_en),      wr);
      chk({tag, ".ram_add"},    int'(ram_add),    add);
      chk({tag, ".data_in"},    int'(data_in),    dat);
      chk({tag, ".busy"},       int'(busy),       bsy);
      chk({tag, ".frame_done"}, int'(frame_done), fd);
      chk({tag, ".clear_done"}, int'(clear_done), cd);
      chk({tag, ".fill_count"}, int'(fill_count), cnt);
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic c, input logic v,
                               input logic [2:0] d, input int rdy, input int wr,
                               input int add, input int dat, input int bsy,
                               input int fd, input int cd, input int cnt);
      vec_t t;
      t.rst_n = r; t.start = s; t.clr = c; t.vld = v; t.din = d;
      t.rdy = rdy; t.wr = wr; t.add = add; t.dat = dat;
      t.bsy = bsy; t.fd = fd; t.cd = cd; t.cnt = cnt;
      return t;
   endfunction

   // start, eight back-to-back words of value val, then back to IDLE
   task automatic fill_all(input logic [2:0] val);
      drive(1, 1, 0, 0, 3'd0);
      tick();
      for (int k = 0; k < 8; k++) begin
         drive(1, 0, 0, 1, val);
         tick();
      end
      drive(1, 0, 0, 0, 3'd0);
      tick();
   endtask

   initial begin
      // reset held with start/in_valid asserted
      for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 0, 1, 3'd5, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 0, 0, 3'd0, 0, 0, 0, 0, 1, 0, 0, 0));
      // back-to-back frame 0..7; frame_done lands with ram_add=7
      for (int k = 0; k < 8; k++)
         vecs.push_back(mk(1, 0, 0, 1, 3'(k), 1, 1, k, k, (k < 7) ? 1 : 0,
                           (k == 7) ? 1 : 0, 0, k + 1));
      vecs.push_back(mk(1, 0, 0, 0, 3'd0, 0, 0, 7, 7, 0, 0, 0, 8));
      // in_valid with in_ready low: ignored, fill_count holds
      vecs.push_back(mk(1, 0, 0, 1, 3'd3, 0, 0, 7, 7, 0, 0, 0, 8));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst_n, vecs[i].start, vecs[i].clr, vecs[i].vld, vecs[i].din);
         #1;
         chk($sformatf("vec%0d.in_ready", i), int'(in_ready), vecs[i].rdy);
         tick();
         chk_out($sformatf("vec%0d", i), vecs[i].wr, vecs[i].add, vecs[i].dat,
                 vecs[i].bsy, vecs[i].fd, vecs[i].cd, vecs[i].cnt);
      end
      for (int a = 0; a < 8; a++) chk($sformatf("b2b.mem%0d", a), int'(mem[a]), a);

      // throttled fill: valid 1,0,1,0... with data 7,6,5,...
      drive(1, 1, 0, 0, 3'd0);
      tick();
      for (int c = 0; c < 16; c++) begin
         drive(1, 0, 0, (c % 2 == 0), 3'(7 - c / 2));
         #1;
         chk($sformatf("thr%0d.in_ready", c), int'(in_ready), (c != 15) ? 1 : 0);
         tick();
         chk_out($sformatf("thr%0d", c), (c % 2 == 0) ? 1 : 0, c / 2, 7 - c / 2,
                 (c < 14) ? 1 : 0, (c == 14) ? 1 : 0, 0, c / 2 + 1);
      end
      drive(1, 0, 0, 0, 3'd0);
      tick();
      for (int a = 0; a < 8; a++) chk($sformatf("thr.mem%0d", a), int'(mem[a]), 7 - a);

      // clear sweep over a RAM preloaded with 7s
      fill_all(3'd7);
      for (int a = 0; a < 8; a++) chk($sformatf("pre.mem%0d", a), int'(mem[a]), 7);
      chk("pre.fill_count", int'(fill_count), 8);
      drive(1, 1, 1, 0, 3'd0);
      tick();
      chk_out("clr.enter", 0, 7, 7, 1, 0, 0, 0);
      for (int c = 0; c < 8; c++) begin
         drive(1, 1, (c == 2), 1, 3'd5);
         #1;
         chk($sformatf("clr%0d.in_ready", c), int'(in_ready), 0);
         tick();
         chk_out($sformatf("clr%0d", c), 1, c, 0, (c < 7) ? 1 : 0, 0, (c == 7) ? 1 : 0, 0);
      end
      drive(1, 0, 0, 0, 3'd0);
      tick();
      chk_out("clr.exit", 0, 7, 0, 0, 0, 0, 0);
      for (int a = 0; a < 8; a++) chk($sformatf("clr.mem%0d", a), int'(mem[a]), 0);

      // abort after three words 4,5,6
      drive(1, 1, 0, 0, 3'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0, 1, 3'(4 + k));
         tick();
      end
      chk("abt.fill_count3", int'(fill_count), 3);
      drive(1, 0, 1, 1, 3'd7);
      #1;
      chk("abt.in_ready", int'(in_ready), 0);
      tick();
      chk_out("abt.enter", 0, 2, 6, 1, 0, 0, 0);
      for (int a = 0; a < 3; a++) chk($sformatf("abt.mem%0d", a), int'(mem[a]), 4 + a);
      for (int c = 0; c < 8; c++) begin
         drive(1, 0, 0, 0, 3'd0);
         tick();
         chk($sformatf("abt%0d.frame_done", c), int'(frame_done), 0);
         chk($sformatf("abt%0d.clear_done", c), int'(clear_done), (c == 7) ? 1 : 0);
      end
      tick();
      for (int a = 0; a < 8; a++) chk($sformatf("abt.zero%0d", a), int'(mem[a]), 0);

      // reset in the middle of a sweep at ptr=4
      fill_all(3'd3);
      drive(1, 0, 1, 0, 3'd0);
      tick();
      for (int c = 0; c < 4; c++) begin
         drive(1, 0, 0, 0, 3'd0);
         tick();
      end
      chk("mrst.pre.ram_add", int'(ram_add), 3);
      drive(0, 0, 0, 0, 3'd0);
      tick();
      chk_out("mrst.rst", 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 3'd0);
      tick();
      chk_out("mrst.idle", 0, 0, 0, 0, 0, 0, 0);
      for (int a = 0; a < 8; a++) chk($sformatf("mrst.mem%0d", a), int'(mem[a]), (a < 4) ? 0 : 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_wr_sequencer.md
Name: ram_wr_sequencer

Overview:
Write-side front end for the 8x3 dual-port RAM. It runs on the RAM's write clock and accepts a valid/ready stream of 3-bit words. It loads exactly one frame of DEPTH words into addresses 0..DEPTH-1 in order and drives the RAM's wr_en/ram_add/data_in. It also provides a clear sweep that zero-fills the RAM one address per cycle, so the RAM's own bulk reset is never needed.

Parameters:
DATA_W, 3, word width; matches RAM data width
ADDR_W, 3, RAM address width
DEPTH, 8, words per frame; must equal 2**ADDR_W

Ports:
clk  in  1  write clock, same net as RAM clk_wr
rst_n  in  1  synchronous active-low reset
start  in  1  begin a frame fill; sampled in IDLE only
clear_req  in  1  request a zero-fill sweep; sampled in IDLE and FILL
in_valid  in  1  upstream word valid
in_data  in  DATA_W  upstream word
in_ready  out  1  block accepts in_data this cycle
wr_en  out  1  RAM write enable, registered
ram_add  out  ADDR_W  RAM address, registered
data_in  out  DATA_W  RAM write data, registered
busy  out  1  high in FILL or CLEAR
frame_done  out  1  one-cycle pulse after the last frame word is written
clear_done  out  1  one-cycle pulse after the last zero is written
fill_count  out  ADDR_W+1  words accepted in current/last frame, 0..DEPTH

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; wr_en, ram_add, data_in, busy, frame_done, clear_done and fill_count all 0. in_ready is 0 during reset.
- States: IDLE, FILL, CLEAR, DONE_F, DONE_C. Internal ptr is ADDR_W+1 bits.
- IDLE: in_ready=0, wr_en=0.
  - clear_req=1 -> CLEAR, ptr=0. clear_req has priority over start.
  - else start=1 -> FILL, ptr=0, fill_count=0.
- FILL:
  - in_ready = ~clear_req, combinational from state and clear_req.
  - A transfer occurs when in_valid & in_ready at an edge. At that edge: wr_en<=1, ram_add<=ptr[ADDR_W-1:0], data_in<=in_data, ptr++, fill_count++.
  - With no transfer: wr_en<=0; ram_add and data_in hold.
  - Latency: word accepted at edge N is presented to the RAM during cycle N..N+1 and captured by the RAM at edge N+1.
  - On the DEPTH-th transfer: -> DONE_F at the same edge. in_ready is 0 from the next cycle.
  - clear_req=1 in FILL: no transfer that cycle; -> CLEAR, ptr=0. Partial frame is abandoned and fill_count is cleared to 0.
  - start in FILL is ignored.
- DONE_F: frame_done=1 for exactly one cycle, in the same cycle the last wr_en is high. wr_en<=0 at exit. -> IDLE.
- CLEAR: in_ready=0. Each cycle: wr_en<=1, ram_add<=ptr, data_in<=0, ptr++. After DEPTH writes (addresses 0..DEPTH-1, ascending) -> DONE_C. start and clear_req are ignored here.
- DONE_C: clear_done=1 for one cycle, coinciding with the final zero write. -> IDLE.
- busy = (state==FILL) | (state==CLEAR).
- fill_count saturates at DEPTH. It holds after frame_done until the next start or clear.
- Address wrap: ptr never exceeds DEPTH, so no wrap within a frame. The next frame restarts at address 0.
- rst_n low mid-FILL or mid-CLEAR: next edge returns to IDLE with wr_en=0. No further writes occur, and RAM contents already written are untouched.
- in_valid high while in_ready=0: no effect. Upstream must hold in_data until accepted.

Decomposition:
- Shared package: DATA_W/ADDR_W/DEPTH defaults and the state encoding constants, so the RAM and any read-side sequencer agree on widths.
- No sub-module is needed; a single FSM plus pointer counter is sufficient.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 and in_valid=1 -> all outputs 0, in_ready=0, no wr_en.
- Back-to-back fill: start, then in_valid=1 continuously with in_data=0..7 -> wr_en high 8 consecutive cycles, ram_add=0..7, data_in=0..7. frame_done pulses once, coinciding with ram_add=7. fill_count=8. RAM read of addr 5 returns 5.
- Throttled fill: in_valid toggling 1,0,1,0 with data 7,6,5,... -> writes only on accepted words, addresses contiguous 0..7, frame_done after 8th accept, and no write in idle gaps.
- Clear sweep: preload RAM with 3'b111, pulse clear_req in IDLE -> 8 writes of 0 to addresses 0..7, clear_done pulse, busy high for 8 cycles. All RAM addresses read 0.
- Abort: in FILL after 3 words (addresses 0..2 = 4,5,6), assert clear_req together with in_valid=1 -> that word is not accepted (in_ready=0), CLEAR sweep follows, fill_count=0, no frame_done.
- Mid-op reset: drop rst_n during CLEAR at ptr=4 -> wr_en 0 next cycle, state IDLE. Addresses 4..7 keep their prior values.
